// File: rtl/control_calculadora.sv
// Sequencer for the 4-digit BCD calculator: turns keypad events into operand entry,
// ALU start/done handshaking and display source selection.
module control_calculadora #(
    parameter int MAX_DIGITOS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_codigo,
    input  logic       alu_done,
    input  logic       alu_overflow,
    output logic       digito_en,
    output logic [3:0] digito,
    output logic       sel_operando,
    output logic       borrar,
    output logic       usar_resultado,
    output logic       operacion,
    output logic       alu_start,
    output logic [1:0] mostrar_sel,
    output logic [2:0] contador,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        INGRESO_1 = 3'd0,
        INGRESO_2 = 3'd1,
        CALCULAR  = 3'd2,
        RESULTADO = 3'd3,
        ERROR     = 3'd4
    } estado_t;

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_DIGITOS);

    estado_t       estado_q, estado_d;
    logic          digito_en_q, digito_en_d;
    logic [3:0]    digito_q, digito_d;
    logic          sel_q, sel_d;
    logic          borrar_q, borrar_d;
    logic          usar_q, usar_d;
    logic          operacion_q, operacion_d;
    logic          alu_start_q, alu_start_d;
    logic [1:0]    mostrar_q, mostrar_d;
    logic [2:0]    contador_q, contador_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pend_q, pend_d;

    logic es_digito, es_op, es_igual, es_clear;

    always_comb begin
        es_digito = tecla_valida && (tecla_codigo <= 4'd9);
        es_op     = tecla_valida && ((tecla_codigo == 4'hA) || (tecla_codigo == 4'hB));
        es_igual  = tecla_valida && (tecla_codigo == 4'hE);
        es_clear  = tecla_valida && (tecla_codigo == 4'hF);
    end

    always_comb begin
        estado_d    = estado_q;
        digito_en_d = 1'b0;
        digito_d    = digito_q;
        sel_d       = sel_q;
        borrar_d    = 1'b0;
        usar_d      = 1'b0;
        operacion_d = operacion_q;
        alu_start_d = 1'b0;
        mostrar_d   = mostrar_q;
        contador_d  = contador_q;
        tmo_d       = tmo_q;
        pend_d      = 1'b0;

        if (es_clear) begin
            estado_d    = INGRESO_1;
            borrar_d    = 1'b1;
            contador_d  = 3'd0;
            sel_d       = 1'b0;
            mostrar_d   = 2'b00;
            operacion_d = 1'b0;
            tmo_d       = '0;
        end else if (pend_q) begin
            // Second half of "digit after result": the held digit follows the clear pulse.
            digito_en_d = 1'b1;
            contador_d  = 3'd1;
        end else begin
            case (estado_q)
                INGRESO_1: begin
                    if (es_digito) begin
                        if (contador_q < MAX_CNT) begin
                            digito_en_d = 1'b1;
                            digito_d    = tecla_codigo;
                            contador_d  = contador_q + 3'd1;
                        end
                    end else if (es_op && contador_q != 3'd0) begin
                        operacion_d = tecla_codigo[0];
                        contador_d  = 3'd0;
                        sel_d       = 1'b1;
                        mostrar_d   = 2'b01;
                        estado_d    = INGRESO_2;
                    end
                end
                INGRESO_2: begin
                    if (es_digito) begin
                        if (contador_q < MAX_CNT) begin
                            digito_en_d = 1'b1;
                            digito_d    = tecla_codigo;
                            contador_d  = contador_q + 3'd1;
                        end
                    end else if (es_op && contador_q == 3'd0) begin
                        operacion_d = tecla_codigo[0];
                    end else if (es_igual && contador_q != 3'd0) begin
                        alu_start_d = 1'b1;
                        tmo_d       = '0;
                        estado_d    = CALCULAR;
                    end
                end
                CALCULAR: begin
                    if (alu_done) begin
                        estado_d  = alu_overflow ? ERROR : RESULTADO;
                        mostrar_d = alu_overflow ? 2'b11 : 2'b10;
                    end else if (tmo_q == TMO_LAST) begin
                        estado_d  = ERROR;
                        mostrar_d = 2'b11;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                RESULTADO: begin
                    if (es_digito) begin
                        borrar_d   = 1'b1;
                        digito_d   = tecla_codigo;
                        pend_d     = 1'b1;
                        contador_d = 3'd0;
                        sel_d      = 1'b0;
                        mostrar_d  = 2'b00;
                        estado_d   = INGRESO_1;
                    end else if (es_op) begin
                        usar_d      = 1'b1;
                        operacion_d = tecla_codigo[0];
                        contador_d  = 3'd0;
                        sel_d       = 1'b1;
                        mostrar_d   = 2'b01;
                        estado_d    = INGRESO_2;
                    end
                end
                ERROR: ;
                default: estado_d = INGRESO_1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= INGRESO_1;
            digito_en_q <= 1'b0;
            digito_q    <= 4'd0;
            sel_q       <= 1'b0;
            borrar_q    <= 1'b0;
            usar_q      <= 1'b0;
            operacion_q <= 1'b0;
            alu_start_q <= 1'b0;
            mostrar_q   <= 2'b00;
            contador_q  <= 3'd0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            digito_en_q <= digito_en_d;
            digito_q    <= digito_d;
            sel_q       <= sel_d;
            borrar_q    <= borrar_d;
            usar_q      <= usar_d;
            operacion_q <= operacion_d;
            alu_start_q <= alu_start_d;
            mostrar_q   <= mostrar_d;
            contador_q  <= contador_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
        end
    end

    assign digito_en      = digito_en_q;
    assign digito         = digito_q;
    assign sel_operando   = sel_q;
    assign borrar         = borrar_q;
    assign usar_resultado = usar_q;
    assign operacion      = operacion_q;
    assign alu_start      = alu_start_q;
    assign mostrar_sel    = mostrar_q;
    assign contador       = contador_q;
    assign estado         = estado_q;

endmodule

// File: tb/tb_control_calculadora.sv
// Directed-vector bench for the calculator sequencer; keys are driven between rising edges
// and the registered response is sampled on the following falling edge.
module tb_control_calculadora;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla_codigo = 4'd0;
    logic       alu_done = 1'b0;
    logic       alu_overflow = 1'b0;
    logic       digito_en, sel_operando, borrar, usar_resultado, operacion, alu_start;
    logic [3:0] digito;
    logic [1:0] mostrar_sel;
    logic [2:0] contador, estado;

    int vectors = 0;
    int miscompares = 0;
    int n_dig;

    localparam int S_ING1 = 0, S_ING2 = 1, S_CALC = 2, S_RES = 3, S_ERR = 4;

    control_calculadora #(.MAX_DIGITOS(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .tecla_valida(tecla_valida), .tecla_codigo(tecla_codigo),
        .alu_done(alu_done), .alu_overflow(alu_overflow),
        .digito_en(digito_en), .digito(digito), .sel_operando(sel_operando),
        .borrar(borrar), .usar_resultado(usar_resultado), .operacion(operacion),
        .alu_start(alu_start), .mostrar_sel(mostrar_sel), .contador(contador),
        .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {digito_en, borrar, usar_resultado, alu_start}
    function automatic int pulses();
        return int'({digito_en, borrar, usar_resultado, alu_start});
    endfunction

    task automatic key(input logic [3:0] c);
        @(negedge clk);
        tecla_codigo = c;
        tecla_valida = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0;
    endtask

    task automatic done(input logic ovf);
        @(negedge clk);
        alu_done     = 1'b1;
        alu_overflow = ovf;
        @(negedge clk);
        alu_done     = 1'b0;
        alu_overflow = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_vec({tag, "_estado"}, int'(estado), S_ING1);
        chk_vec({tag, "_pulses"}, pulses(), 0);
        chk_vec({tag, "_mostrar"}, int'(mostrar_sel), 0);
        chk_vec({tag, "_contador"}, int'(contador), 0);
        chk_vec({tag, "_operacion"}, int'(operacion), 0);
        chk_vec({tag, "_sel"}, int'(sel_operando), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");
        chk_vec("rst_digito", int'(digito), 0);

        // Basic 12 + 3 transaction
        key(4'd1);
        chk_vec("t1_d1_pulses", pulses(), 8);
        chk_vec("t1_d1_digito", int'(digito), 1);
        chk_vec("t1_d1_sel", int'(sel_operando), 0);
        key(4'd2);
        chk_vec("t1_d2_pulses", pulses(), 8);
        chk_vec("t1_d2_contador", int'(contador), 2);
        key(4'hA);
        chk_vec("t1_A_pulses", pulses(), 0);
        chk_vec("t1_A_estado", int'(estado), S_ING2);
        chk_vec("t1_A_mostrar", int'(mostrar_sel), 1);
        chk_vec("t1_A_operacion", int'(operacion), 0);
        chk_vec("t1_A_contador", int'(contador), 0);
        key(4'd3);
        chk_vec("t1_d3_pulses", pulses(), 8);
        chk_vec("t1_d3_sel", int'(sel_operando), 1);
        chk_vec("t1_d3_digito", int'(digito), 3);
        key(4'hE);
        chk_vec("t1_E_pulses", pulses(), 1);
        chk_vec("t1_E_estado", int'(estado), S_CALC);
        @(negedge clk);
        chk_vec("t1_start_once", pulses(), 0);
        done(1'b0);
        chk_vec("t1_res_estado", int'(estado), S_RES);
        chk_vec("t1_res_mostrar", int'(mostrar_sel), 2);

        // Digit limit
        key(4'hF);
        chk_vec("t2_F_pulses", pulses(), 4);
        chk_vec("t2_F_estado", int'(estado), S_ING1);
        n_dig = 0;
        for (int i = 1; i <= 5; i++) begin
            key(4'(i));
            n_dig += int'(digito_en);
        end
        chk_vec("t2_ndig", n_dig, 4);
        chk_vec("t2_5th_pulses", pulses(), 0);
        chk_vec("t2_contador", int'(contador), 4);

        // Operators with zero digits, operator overwrite
        key(4'hF);
        key(4'hA);
        chk_vec("t3_A0_estado", int'(estado), S_ING1);
        chk_vec("t3_A0_pulses", pulses(), 0);
        key(4'hE);
        chk_vec("t3_E0_estado", int'(estado), S_ING1);
        chk_vec("t3_E0_pulses", pulses(), 0);
        key(4'd7);
        key(4'hB);
        chk_vec("t3_B_operacion", int'(operacion), 1);
        chk_vec("t3_B_estado", int'(estado), S_ING2);
        key(4'hA);
        chk_vec("t3_A_operacion", int'(operacion), 0);
        chk_vec("t3_A_sel", int'(sel_operando), 1);
        key(4'hE);
        chk_vec("t3_E0b_estado", int'(estado), S_ING2);
        key(4'd2);
        chk_vec("t3_d2_pulses", pulses(), 8);
        chk_vec("t3_d2_contador", int'(contador), 1);
        key(4'hB);
        chk_vec("t3_Blate_operacion", int'(operacion), 0);

        // ALU timeout
        key(4'hE);
        chk_vec("t4_E_pulses", pulses(), 1);
        repeat (63) @(negedge clk);
        chk_vec("t4_63_estado", int'(estado), S_CALC);
        @(negedge clk);
        chk_vec("t4_64_estado", int'(estado), S_ERR);
        chk_vec("t4_64_mostrar", int'(mostrar_sel), 3);
        key(4'd5);
        chk_vec("t4_dig_pulses", pulses(), 0);
        chk_vec("t4_dig_estado", int'(estado), S_ERR);
        done(1'b0);
        chk_vec("t4_done_estado", int'(estado), S_ERR);
        key(4'hF);
        chk_vec("t4_F_pulses", pulses(), 4);
        chk_vec("t4_F_estado", int'(estado), S_ING1);
        chk_vec("t4_F_mostrar", int'(mostrar_sel), 0);

        // Result followed by a digit, then a chained operation
        key(4'd1); key(4'hA); key(4'd2); key(4'hE);
        done(1'b0);
        chk_vec("t5_res_estado", int'(estado), S_RES);
        key(4'd8);
        chk_vec("t5_d8_pulses", pulses(), 4);
        chk_vec("t5_d8_estado", int'(estado), S_ING1);
        @(negedge clk);
        chk_vec("t5_d8b_pulses", pulses(), 8);
        chk_vec("t5_d8b_digito", int'(digito), 8);
        chk_vec("t5_d8b_contador", int'(contador), 1);
        chk_vec("t5_d8b_sel", int'(sel_operando), 0);
        key(4'hA); key(4'd4); key(4'hE);
        done(1'b0);
        chk_vec("t5_res2_estado", int'(estado), S_RES);
        key(4'hE);
        chk_vec("t5_Eres_pulses", pulses(), 0);
        chk_vec("t5_Eres_estado", int'(estado), S_RES);
        key(4'hB);
        chk_vec("t5_B_pulses", pulses(), 2);
        chk_vec("t5_B_operacion", int'(operacion), 1);
        chk_vec("t5_B_estado", int'(estado), S_ING2);
        chk_vec("t5_B_sel", int'(sel_operando), 1);
        chk_vec("t5_B_contador", int'(contador), 0);
        key(4'd9); key(4'hE);
        chk_vec("t5_E_pulses", pulses(), 1);
        done(1'b1);
        chk_vec("t5_ovf_estado", int'(estado), S_ERR);
        chk_vec("t5_ovf_mostrar", int'(mostrar_sel), 3);
        key(4'hF);

        // Reset in the middle of a calculation
        key(4'd1); key(4'hA); key(4'd2); key(4'hE);
        chk_vec("t6_calc_estado", int'(estado), S_CALC);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        done(1'b0);
        chk_reset_vals("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
